// File: rtl/cpu_out_display.sv
// Shows the CPU's 8-bit output value as unsigned decimal on a 4-digit multiplexed
// common-anode seven-segment display, using a sequential double-dabble converter.
module cpu_out_display #(
   parameter int REFRESH_COUNT = 100000,
   parameter int LZ_BLANK      = 1
) (
   input  logic        boardCLK,
   input  logic        reset,
   input  logic [7:0]  cpuOut,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [11:0] bcd,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   // Handshake: busy rises the edge after a new cpuOut value is accepted and falls
   // on the same edge that bcd is updated; bcd is a completed result whenever busy is low.
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

   localparam int CW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
   localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_COUNT - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   state_t       state, state_nxt;
   logic [7:0]   last_value, last_nxt;
   logic [7:0]   shreg, shreg_nxt;
   logic [11:0]  scratch, scratch_nxt, adj;
   logic [11:0]  bcd_nxt;
   logic [3:0]   iter, iter_nxt;
   logic         busy_nxt;

   logic [CW-1:0] refresh_cnt;
   logic [1:0]    digit_idx;
   logic [6:0]    seg_nxt;
   logic [3:0]    an_nxt;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b1000000;
         4'd1:    seg_code = 7'b1111001;
         4'd2:    seg_code = 7'b0100100;
         4'd3:    seg_code = 7'b0110000;
         4'd4:    seg_code = 7'b0011001;
         4'd5:    seg_code = 7'b0010010;
         4'd6:    seg_code = 7'b0000010;
         4'd7:    seg_code = 7'b1111000;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0010000;
         default: seg_code = SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction applied to every scratch nibble before each shift.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < 3; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_nxt   = state;
      last_nxt    = last_value;
      shreg_nxt   = shreg;
      scratch_nxt = scratch;
      iter_nxt    = iter;
      bcd_nxt     = bcd;
      busy_nxt    = busy;
      case (state)
         IDLE: begin
            if (cpuOut != last_value) begin
               shreg_nxt   = cpuOut;
               last_nxt    = cpuOut;
               scratch_nxt = 12'h000;
               iter_nxt    = 4'd0;
               busy_nxt    = 1'b1;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_nxt, shreg_nxt} = {adj, shreg} << 1;
            iter_nxt = iter + 4'd1;
            if (iter == 4'd7) state_nxt = DONE;
         end
         DONE: begin
            bcd_nxt   = scratch;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge boardCLK or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_value <= 8'h00;
         shreg      <= 8'h00;
         scratch    <= 12'h000;
         iter       <= 4'd0;
         bcd        <= 12'h000;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_value <= last_nxt;
         shreg      <= shreg_nxt;
         scratch    <= scratch_nxt;
         iter       <= iter_nxt;
         bcd        <= bcd_nxt;
         busy       <= busy_nxt;
      end
   end

   always_ff @(posedge boardCLK or posedge reset) begin
      if (reset) begin
         refresh_cnt <= '0;
         digit_idx   <= 2'd0;
      end else if (refresh_cnt == REFRESH_LAST) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 1'b1;
      end
   end

   // Anode and segments are both registered from digit_idx so they switch on the same edge.
   always_comb begin
      an_nxt  = ~(4'b0001 << digit_idx);
      seg_nxt = SEG_BLANK;
      case (digit_idx)
         2'd0: seg_nxt = seg_code(bcd[3:0]);
         2'd1: if (!((LZ_BLANK != 0) && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0))
                  seg_nxt = seg_code(bcd[7:4]);
         2'd2: if (!((LZ_BLANK != 0) && bcd[11:8] == 4'd0))
                  seg_nxt = seg_code(bcd[11:8]);
         default: seg_nxt = SEG_BLANK;
      endcase
   end

   always_ff @(posedge boardCLK or posedge reset) begin
      if (reset) begin
         an  <= 4'b1110;
         seg <= 7'b1000000;
         dp  <= 1'b1;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
         dp  <= 1'b1;
      end
   end

   assign state_dbg = state;

endmodule
